uart_mmio_bridge: RTL and testbench
===================================

Name: uart_mmio_bridge

Overview:
- Memory-mapped register front-end between the RISC-V core's load/store port and the UART duplex block.
- CPU stores to TXDATA become single-cycle send pulses with a data byte into the duplex TX FIFO.
- Completed RX bytes, detected on rising edges of rx_done_flag, are captured with their error flags into a local RX FIFO that the CPU pops by reading RXDATA.
- The block also owns the parity/baud configuration, sticky status flags and an interrupt line.

Parameters:
- RX_DEPTH, 8, local RX FIFO entries; power of two, minimum 2.
- BAUD_RST, 2'b00, reset value of the baud_rate output.
- PARITY_RST, 2'b00, reset value of the parity_type output.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- bus_addr  in  4  byte address; bits [3:2] select the register, bits [1:0] are ignored
- bus_we  in  1  write strobe, one clock
- bus_re  in  1  read strobe, one clock
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, registered
- bus_rvalid  out  1  high for exactly one clock, the clock after bus_re
- send  out  1  one-clock push pulse to the duplex TX FIFO
- data_in  out  8  byte accompanying send; held until the next accepted write
- parity_type  out  2  duplex parity configuration
- baud_rate  out  2  duplex baud configuration
- tx_fifo_full  in  1  duplex TX FIFO full
- tx_fifo_empty  in  1  duplex TX FIFO empty
- tx_active_flag  in  1  transmission in progress
- rx_done_flag  in  1  receive complete; may stay high for many clocks
- rx_data  in  8  received byte, valid while rx_done_flag=1
- rx_error  in  3  {stop, start, parity} error flags, valid with rx_done_flag
- irq  out  1  registered interrupt request

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Outputs: send=0, data_in=0, parity_type=PARITY_RST, baud_rate=BAUD_RST, bus_rdata=0, bus_rvalid=0, irq=0.
  - Internal state: RX FIFO emptied, sticky flags cleared, irq enables cleared, rx_done_q=0.
  - A reset mid-operation discards all FIFO contents.
- Register map (offset, access, content):
  - 0x0 TXDATA (W): bits [7:0] carry the byte to send.
  - 0x4 RXDATA (R): {valid[31], 20'b0, err[10:8], byte[7:0]}.
  - 0x8 STATUS (R, W1C on bits [7:4]):
    - [0] rx_nonempty
    - [1] rx_full
    - [2] tx_fifo_full
    - [3] tx_fifo_empty
    - [4] rx_overflow
    - [5] tx_overflow
    - [6] rx_err_sticky
    - [7] cfg_reject
  - 0xC CTRL (RW): [1:0] parity, [3:2] baud, [4] rx_irq_en, [5] err_irq_en.
- TXDATA write:
  - If tx_fifo_full=0: send=1 on the next clock, data_in=bus_wdata[7:0] on the same clock.
  - If tx_fifo_full=1: no pulse, data_in unchanged, tx_overflow set.
  - Back-to-back writes each produce their own pulse, each judged by tx_fifo_full in its own cycle.
- CTRL write:
  - Bits [5:4] always update.
  - Bits [3:0] update only if tx_fifo_empty=1 and tx_active_flag=0. Otherwise they are ignored and cfg_reject is set.
- RX capture:
  - rx_done_q registers rx_done_flag. A push happens when rx_done_flag & ~rx_done_q, storing {rx_error, rx_data} (11 bits).
  - A push also ORs rx_error into rx_err_sticky, even when the push is dropped for overflow.
  - FIFO full with no simultaneous pop: push dropped, rx_overflow set.
  - FIFO full with a simultaneous pop: both proceed, no overflow.
  - FIFO empty with a simultaneous push and pop: the read returns valid=0 with the other fields 0; the push lands.
- RXDATA read: one-cycle latency; bus_rdata carries the head entry with valid=1, and the pop happens on the same edge. Reading while empty returns 0 and pops nothing.
- Other reads are side-effect free. Reads and writes to unmapped offsets do not exist, since the 2-bit select covers all four. If bus_we and bus_re are high together, the write takes effect and the read returns pre-write data.
- W1C: writing 1 to any of STATUS bits [7:4] clears that bit. If a set event occurs in the same cycle, set wins.
- irq = registered (rx_irq_en & rx_nonempty) | (err_irq_en & |STATUS[7:4]).
- Pointers are log2(RX_DEPTH)+1 bits wide, with an extra wrap bit. full = MSBs differ and LSBs equal; wrap-around is natural overflow.

Decomposition:
- uart_pkg holds:
  - register offset localparams REG_TXDATA, REG_RXDATA, REG_STATUS, REG_CTRL;
  - STATUS bit index constants;
  - error index constants ERR_PARITY=0, ERR_START=1, ERR_STOP=2;
  - the rx_entry_t packed struct {err[2:0], data[7:0]}.
- One sub-module, uart_rx_capture_fifo: edge detect, synchronous FIFO, and overflow/sticky-error generation.
- The bus decode, TX pulse and CTRL/STATUS logic stay in the top module.

Test Plan:
- Write 0x41 to 0x0 with tx_fifo_full=0 -> send=1 for exactly 1 clock, data_in=0x41. Repeat with tx_fifo_full=1 -> no pulse, STATUS[5]=1.
- Hold rx_done_flag high 20 clocks with rx_data=0x5A, rx_error=0 -> exactly one entry. Read 0x4 -> 0x8000005A with rvalid one clock later. Second read -> 0x00000000.
- Push 9 bytes with RX_DEPTH=8 -> STATUS[1]=1, STATUS[4]=1, first 8 bytes read back in order. Write 0x10 to 0x8 -> STATUS[4]=0.
- RX entry with rx_error=3'b001 and CTRL=0x20 -> STATUS[6]=1, irq=1, RXDATA=0x800001xx. Write 0x40 to 0x8 -> irq deasserts one clock later.
- CTRL write 0x0F with tx_active_flag=1 -> parity/baud unchanged, STATUS[7]=1. With the TX side idle -> parity_type=3, baud_rate=3.
- Assert reset_n=0 with 3 RX entries pending and a send in flight -> all outputs at reset values immediately, RX FIFO empty after release.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART MMIO bridge.
//   - Register select codes (bus_addr[3:2]) for TXDATA, RXDATA, STATUS, CTRL.
//   - STATUS bit positions and rx_error bit positions.
//   - rx_entry_t: one RX FIFO entry {err[2:0], data[7:0]}.
//   - rxdata_word(): formats a FIFO head entry as the RXDATA read word.
package uart_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_RXDATA = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int ST_RX_NONEMPTY = 0;
   localparam int ST_RX_FULL     = 1;
   localparam int ST_TX_FULL     = 2;
   localparam int ST_TX_EMPTY    = 3;
   localparam int ST_RX_OVERFLOW = 4;
   localparam int ST_TX_OVERFLOW = 5;
   localparam int ST_RX_ERR      = 6;
   localparam int ST_CFG_REJECT  = 7;

   localparam int ERR_PARITY = 0;
   localparam int ERR_START  = 1;
   localparam int ERR_STOP   = 2;

   typedef struct packed {
      logic [2:0] err;
      logic [7:0] data;
   } rx_entry_t;

   // Valid head entry as seen by the CPU: {valid, 20'b0, err, byte}.
   function automatic logic [31:0] rxdata_word(input rx_entry_t e);
      return {1'b1, 20'b0, e.err, e.data};
   endfunction

endpackage

// File: rtl/uart_rx_capture_fifo.sv
// uart_rx_capture_fifo: rising-edge capture of completed RX bytes into a
// synchronous FIFO, plus overflow / error event generation.
// Ports:
//   i_clock, i_reset_n      clock, asynchronous active-low reset
//   i_rx_done_flag          receive complete level (edge detected here)
//   i_rx_data, i_rx_error   byte and {stop,start,parity} flags at the edge
//   i_pop_req               CPU read of RXDATA (ignored while empty)
//   o_head                  current head entry
//   o_empty, o_full         FIFO occupancy
//   o_ovf_evt               push dropped because FIFO full and no pop
//   o_err_evt               a push carried at least one error flag
module uart_rx_capture_fifo
   import uart_pkg::*;
#(
   parameter int RX_DEPTH = 8
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_rx_done_flag,
   input  logic [7:0] i_rx_data,
   input  logic [2:0] i_rx_error,
   input  logic       i_pop_req,
   output rx_entry_t  o_head,
   output logic       o_empty,
   output logic       o_full,
   output logic       o_ovf_evt,
   output logic       o_err_evt
);

   localparam int AW = $clog2(RX_DEPTH);

   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        r_done_q;
   rx_entry_t   r_mem [RX_DEPTH];

   logic w_push;
   logic w_pop;
   logic w_write;

   assign o_empty = (r_wptr == r_rptr);
   // Extra wrap bit distinguishes full from empty when the indices match.
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_head  = r_mem[r_rptr[AW-1:0]];

   assign w_push  = i_rx_done_flag & ~r_done_q;
   assign w_pop   = i_pop_req & ~o_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_write = w_push & (~o_full | w_pop);

   assign o_ovf_evt = w_push & o_full & ~w_pop;
   assign o_err_evt = w_push & (|i_rx_error);

   // Pointers and edge-detect register.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_done_q <= 1'b0;
      end else begin
         r_done_q <= i_rx_done_flag;
         if (w_write) r_wptr <= r_wptr + 1'b1;
         if (w_pop)   r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge i_clock) begin
      if (w_write) r_mem[r_wptr[AW-1:0]] <= '{err: i_rx_error, data: i_rx_data};
   end

endmodule

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: CPU register front-end for the UART duplex block.
// Ports:
//   clock, reset_n                       clock, asynchronous active-low reset
//   bus_addr/we/re/wdata                 CPU access; bus_addr[3:2] selects register
//   bus_rdata, bus_rvalid                registered read response, 1 clock after bus_re
//   send, data_in                        TX FIFO push pulse and byte
//   parity_type, baud_rate               duplex configuration
//   tx_fifo_full/empty, tx_active_flag   TX side status
//   rx_done_flag, rx_data, rx_error      RX completion inputs
//   irq                                  registered interrupt request
module uart_mmio_bridge
   import uart_pkg::*;
#(
   parameter int         RX_DEPTH   = 8,
   parameter logic [1:0] BAUD_RST   = 2'b00,
   parameter logic [1:0] PARITY_RST = 2'b00
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [3:0]  bus_addr,
   input  logic        bus_we,
   input  logic        bus_re,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_rvalid,
   output logic        send,
   output logic [7:0]  data_in,
   output logic [1:0]  parity_type,
   output logic [1:0]  baud_rate,
   input  logic        tx_fifo_full,
   input  logic        tx_fifo_empty,
   input  logic        tx_active_flag,
   input  logic        rx_done_flag,
   input  logic [7:0]  rx_data,
   input  logic [2:0]  rx_error,
   output logic        irq
);

   localparam int STK = ST_RX_OVERFLOW;   // r_sticky[0] is STATUS[4]

   logic        r_send;
   logic [7:0]  r_data_in;
   logic [1:0]  r_parity;
   logic [1:0]  r_baud;
   logic        r_rx_irq_en;
   logic        r_err_irq_en;
   logic [3:0]  r_sticky;
   logic [31:0] r_rdata;
   logic        r_rvalid;
   logic        r_irq;

   logic [1:0]  w_sel;
   logic        w_wr_tx, w_wr_status, w_wr_ctrl, w_rd_rx, w_cfg_ok;
   rx_entry_t   w_head;
   logic        w_empty, w_full, w_ovf_evt, w_err_evt;
   logic [3:0]  w_sticky_set, w_sticky_clr;
   logic [7:0]  w_status;
   logic [31:0] w_ctrl;
   logic [31:0] w_rd_mux;
   logic        w_unused;

   assign w_sel       = bus_addr[3:2];
   assign w_wr_tx     = bus_we & (w_sel == REG_TXDATA);
   assign w_wr_status = bus_we & (w_sel == REG_STATUS);
   assign w_wr_ctrl   = bus_we & (w_sel == REG_CTRL);
   assign w_rd_rx     = bus_re & (w_sel == REG_RXDATA);
   assign w_cfg_ok    = tx_fifo_empty & ~tx_active_flag;
   assign w_unused    = ^{bus_addr[1:0], bus_wdata[31:8]};

   uart_rx_capture_fifo #(.RX_DEPTH(RX_DEPTH)) u_rx_fifo (
      .i_clock        (clock),
      .i_reset_n      (reset_n),
      .i_rx_done_flag (rx_done_flag),
      .i_rx_data      (rx_data),
      .i_rx_error     (rx_error),
      .i_pop_req      (w_rd_rx),
      .o_head         (w_head),
      .o_empty        (w_empty),
      .o_full         (w_full),
      .o_ovf_evt      (w_ovf_evt),
      .o_err_evt      (w_err_evt)
   );

   assign w_sticky_set[ST_RX_OVERFLOW - STK] = w_ovf_evt;
   assign w_sticky_set[ST_TX_OVERFLOW - STK] = w_wr_tx & tx_fifo_full;
   assign w_sticky_set[ST_RX_ERR      - STK] = w_err_evt;
   assign w_sticky_set[ST_CFG_REJECT  - STK] = w_wr_ctrl & ~w_cfg_ok;
   assign w_sticky_clr = w_wr_status ? bus_wdata[7:4] : 4'b0000;

   assign w_status = {r_sticky, tx_fifo_empty, tx_fifo_full, w_full, ~w_empty};
   assign w_ctrl   = {26'b0, r_err_irq_en, r_rx_irq_en, r_baud, r_parity};

   // Read data mux; reflects state before any same-cycle write.
   always_comb begin
      w_rd_mux = 32'h0000_0000;
      case (w_sel)
         REG_RXDATA: begin
            if (!w_empty) w_rd_mux = rxdata_word(w_head);
            else          w_rd_mux = 32'h0000_0000;
         end
         REG_STATUS: w_rd_mux = {24'b0, w_status};
         REG_CTRL:   w_rd_mux = w_ctrl;
         default:    w_rd_mux = 32'h0000_0000;
      endcase
   end

   // Bus response, TX pulse, configuration, sticky flags and interrupt.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_send       <= 1'b0;
         r_data_in    <= 8'h00;
         r_parity     <= PARITY_RST;
         r_baud       <= BAUD_RST;
         r_rx_irq_en  <= 1'b0;
         r_err_irq_en <= 1'b0;
         r_sticky     <= 4'b0000;
         r_rdata      <= 32'h0000_0000;
         r_rvalid     <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         r_send   <= w_wr_tx & ~tx_fifo_full;
         if (w_wr_tx && !tx_fifo_full) r_data_in <= bus_wdata[7:0];
         if (w_wr_ctrl) begin
            r_rx_irq_en  <= bus_wdata[4];
            r_err_irq_en <= bus_wdata[5];
            if (w_cfg_ok) begin
               r_parity <= bus_wdata[1:0];
               r_baud   <= bus_wdata[3:2];
            end
         end
         // Set has priority over a same-cycle W1C.
         r_sticky <= w_sticky_set | (r_sticky & ~w_sticky_clr);
         r_rvalid <= bus_re;
         r_rdata  <= bus_re ? w_rd_mux : 32'h0000_0000;
         r_irq    <= (r_rx_irq_en & ~w_empty) | (r_err_irq_en & (|r_sticky));
      end
   end

   assign send        = r_send;
   assign data_in     = r_data_in;
   assign parity_type = r_parity;
   assign baud_rate   = r_baud;
   assign bus_rdata   = r_rdata;
   assign bus_rvalid  = r_rvalid;
   assign irq         = r_irq;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge: directed scenarios plus randomized traffic, checked
// every clock against a queue-based reference model of the register block.
module tb_uart_mmio_bridge;

   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  bus_addr = 4'h0;
   logic        bus_we = 1'b0;
   logic        bus_re = 1'b0;
   logic [31:0] bus_wdata = 32'h0;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;
   logic        send;
   logic [7:0]  data_in;
   logic [1:0]  parity_type;
   logic [1:0]  baud_rate;
   logic        tx_fifo_full = 1'b0;
   logic        tx_fifo_empty = 1'b1;
   logic        tx_active_flag = 1'b0;
   logic        rx_done_flag = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic [2:0]  rx_error = 3'b000;
   logic        irq;

   int checks = 0;
   int failures = 0;

   uart_mmio_bridge #(.RX_DEPTH(DEPTH), .BAUD_RST(2'b00), .PARITY_RST(2'b00)) dut (
      .clock(clock), .reset_n(reset_n),
      .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
      .send(send), .data_in(data_in), .parity_type(parity_type), .baud_rate(baud_rate),
      .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty), .tx_active_flag(tx_active_flag),
      .rx_done_flag(rx_done_flag), .rx_data(rx_data), .rx_error(rx_error), .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [10:0] m_q[$];
   logic        m_done_q;
   logic [3:0]  m_sticky;     // STATUS[7:4]
   logic [1:0]  m_parity, m_baud;
   logic        m_rxie, m_erie;
   logic        e_send, e_rvalid, e_irq;
   logic [7:0]  e_data_in;
   logic [31:0] e_rdata;

   task automatic model_reset();
      m_q.delete();
      m_done_q = 1'b0; m_sticky = 4'h0;
      m_parity = 2'b00; m_baud = 2'b00; m_rxie = 1'b0; m_erie = 1'b0;
      e_send = 1'b0; e_rvalid = 1'b0; e_irq = 1'b0; e_data_in = 8'h00; e_rdata = 32'h0;
   endtask

   // Advance the model by one clock using the inputs that the next edge samples.
   task automatic model_step();
      logic [1:0]  sel;
      logic [31:0] rd_w;
      logic        pop, push, fullq, nonempty;
      logic [3:0]  set, clr;
      sel      = bus_addr[3:2];
      nonempty = (m_q.size() != 0);
      fullq    = (m_q.size() == DEPTH);
      e_irq    = (m_rxie && nonempty) || (m_erie && (m_sticky != 4'h0));
      rd_w = 32'h0;
      case (sel)
         2'd1: if (nonempty) rd_w = {1'b1, 20'b0, m_q[0]};
         2'd2: rd_w = {24'b0, m_sticky, tx_fifo_empty, tx_fifo_full, fullq, nonempty};
         2'd3: rd_w = {26'b0, m_erie, m_rxie, m_baud, m_parity};
         default: rd_w = 32'h0;
      endcase
      pop  = bus_re && (sel == 2'd1) && nonempty;
      push = rx_done_flag && !m_done_q;
      set[0] = push && fullq && !pop;
      set[1] = bus_we && (sel == 2'd0) && tx_fifo_full;
      set[2] = push && (rx_error != 3'b000);
      set[3] = bus_we && (sel == 2'd3) && !(tx_fifo_empty && !tx_active_flag);
      clr = (bus_we && sel == 2'd2) ? bus_wdata[7:4] : 4'h0;
      m_sticky = set | (m_sticky & ~clr);
      if (pop) m_q.delete(0);
      if (push && !(fullq && !pop)) m_q.push_back({rx_error, rx_data});
      if (bus_we && sel == 2'd3) begin
         m_rxie = bus_wdata[4];
         m_erie = bus_wdata[5];
         if (tx_fifo_empty && !tx_active_flag) begin
            m_parity = bus_wdata[1:0];
            m_baud   = bus_wdata[3:2];
         end
      end
      e_send = bus_we && (sel == 2'd0) && !tx_fifo_full;
      if (e_send) e_data_in = bus_wdata[7:0];
      e_rvalid = bus_re;
      if (bus_re) e_rdata = rd_w;
      m_done_q = rx_done_flag;
   endtask

   // Compare process: check outputs after each edge, then advance the model.
   initial begin
      model_reset();
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            model_reset();
         end else begin
            chk("send", {31'b0, send}, {31'b0, e_send});
            chk("data_in", {24'b0, data_in}, {24'b0, e_data_in});
            chk("parity_type", {30'b0, parity_type}, {30'b0, m_parity});
            chk("baud_rate", {30'b0, baud_rate}, {30'b0, m_baud});
            chk("bus_rvalid", {31'b0, bus_rvalid}, {31'b0, e_rvalid});
            chk("irq", {31'b0, irq}, {31'b0, e_irq});
            if (e_rvalid) chk("bus_rdata", bus_rdata, e_rdata);
            model_step();
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      step(); bus_addr = a; bus_wdata = d; bus_we = 1'b1;
      step(); bus_we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      step(); bus_addr = a; bus_re = 1'b1;
      step(); bus_re = 1'b0; d = bus_rdata;
   endtask

   task automatic rx_byte(input logic [7:0] d, input logic [2:0] e, input int hold);
      step(); rx_data = d; rx_error = e; rx_done_flag = 1'b1;
      repeat (hold - 1) step();
      step(); rx_done_flag = 1'b0;
      step();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_send"}, {31'b0, send}, 32'h0);
      chk({tag, "_data_in"}, {24'b0, data_in}, 32'h0);
      chk({tag, "_parity"}, {30'b0, parity_type}, 32'h0);
      chk({tag, "_baud"}, {30'b0, baud_rate}, 32'h0);
      chk({tag, "_rdata"}, bus_rdata, 32'h0);
      chk({tag, "_rvalid"}, {31'b0, bus_rvalid}, 32'h0);
      chk({tag, "_irq"}, {31'b0, irq}, 32'h0);
   endtask

   logic [31:0] rv;
   logic [31:0] rnd;

   initial begin
      #2;
      chk_reset_outputs("reset0");
      step(); step(); reset_n = 1'b1;
      step();

      // TX write accepted, then rejected while the TX FIFO is full.
      wr(4'h0, 32'h0000_0041);
      chk("tx_pulse", {31'b0, send}, 32'h1);
      chk("tx_byte", {24'b0, data_in}, 32'h41);
      step();
      chk("tx_pulse_end", {31'b0, send}, 32'h0);
      tx_fifo_full = 1'b1;
      wr(4'h0, 32'h0000_0099);
      chk("tx_full_nopulse", {31'b0, send}, 32'h0);
      chk("tx_full_hold", {24'b0, data_in}, 32'h41);
      rd(4'h8, rv);
      chk("tx_overflow", {31'b0, rv[5]}, 32'h1);
      tx_fifo_full = 1'b0;
      wr(4'h8, 32'h0000_0020);

      // Long rx_done level produces a single entry.
      rx_byte(8'h5A, 3'b000, 20);
      rd(4'h4, rv);
      chk("rx_single", rv, 32'h8000_005A);
      rd(4'h4, rv);
      chk("rx_empty_read", rv, 32'h0000_0000);

      // Overflow: nine pushes into an eight-deep FIFO.
      for (int i = 1; i <= 9; i++) rx_byte(8'(i), 3'b000, 1);
      rd(4'h8, rv);
      chk("rx_full_flag", {31'b0, rv[1]}, 32'h1);
      chk("rx_ovf_flag", {31'b0, rv[4]}, 32'h1);
      for (int i = 1; i <= 8; i++) begin
         rd(4'h4, rv);
         chk("rx_order", rv, 32'h8000_0000 | 32'(i));
      end
      wr(4'h8, 32'h0000_0010);
      rd(4'h8, rv);
      chk("rx_ovf_w1c", {31'b0, rv[4]}, 32'h0);

      // Error entry with error interrupt enabled.
      wr(4'hC, 32'h0000_0020);
      rx_byte(8'h33, 3'b001, 1);
      rd(4'h8, rv);
      chk("rx_err_sticky", {31'b0, rv[6]}, 32'h1);
      chk("err_irq", {31'b0, irq}, 32'h1);
      rd(4'h4, rv);
      chk("rx_err_entry", rv, 32'h8000_0133);
      wr(4'h8, 32'h0000_0040);
      chk("irq_lag", {31'b0, irq}, 32'h1);
      step();
      chk("irq_cleared", {31'b0, irq}, 32'h0);

      // Configuration gated by TX activity.
      tx_active_flag = 1'b1;
      wr(4'hC, 32'h0000_000F);
      chk("cfg_rej_parity", {30'b0, parity_type}, 32'h0);
      chk("cfg_rej_baud", {30'b0, baud_rate}, 32'h0);
      rd(4'h8, rv);
      chk("cfg_reject", {31'b0, rv[7]}, 32'h1);
      tx_active_flag = 1'b0;
      wr(4'hC, 32'h0000_000F);
      chk("cfg_parity", {30'b0, parity_type}, 32'h3);
      chk("cfg_baud", {30'b0, baud_rate}, 32'h3);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         step();
         rnd = $urandom;
         bus_addr       = rnd[3:0];
         bus_we         = ($urandom_range(3, 0) == 0);
         bus_re         = ($urandom_range(2, 0) == 0);
         bus_wdata      = $urandom;
         tx_fifo_full   = ($urandom_range(2, 0) == 0);
         tx_fifo_empty  = rnd[8];
         tx_active_flag = rnd[9];
         if ($urandom_range(3, 0) == 0) rx_done_flag = ~rx_done_flag;
         rx_data        = rnd[23:16];
         rx_error       = (rnd[27:26] == 2'b00) ? rnd[30:28] : 3'b000;
      end
      step();
      bus_we = 1'b0; bus_re = 1'b0; rx_done_flag = 1'b0; rx_error = 3'b000;
      tx_fifo_full = 1'b0; tx_fifo_empty = 1'b1; tx_active_flag = 1'b0;
      step(); step();

      // Reset with RX entries pending and a send pulse in flight.
      for (int i = 0; i < 3; i++) rx_byte(8'hA0 + 8'(i), 3'b000, 2);
      wr(4'h0, 32'h0000_0077);
      chk("pre_reset_send", {31'b0, send}, 32'h1);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("reset_mid");
      step(); step(); reset_n = 1'b1;
      step();
      rd(4'h8, rv);
      chk("post_reset_nonempty", {31'b0, rv[0]}, 32'h0);
      rd(4'h4, rv);
      chk("post_reset_rx", rv, 32'h0);
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
